// File: rtl/ee201_numlock_ctrl.sv
`default_nettype none
// ============================================================================
// ee201_numlock_ctrl : button conditioning, opening timer and failure lockout
// Rev 1.0
// ============================================================================
module ee201_numlock_ctrl #(
  parameter int unsigned OPEN_CYCLES    = 16,
  parameter int unsigned LOCKOUT_CYCLES = 32,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       btn_u,
  input  logic       btn_z,
  input  logic       q_opening,
  input  logic       q_bad,
  output logic       u,
  output logic       z,
  output logic       timerout,
  output logic       locked_out,
  output logic [3:0] fail_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKOUT = 2'd1,
    ST_REARM   = 2'd2
  } state_t;

  localparam logic [7:0] c_open_max  = 8'(OPEN_CYCLES);
  localparam logic [7:0] c_open_last = 8'(OPEN_CYCLES - 1);
  localparam logic [7:0] c_lock_last = 8'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0] c_max_fails = 4'(MAX_FAILS);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_open_tmr;
  logic [7:0] r_lock_cnt;
  logic       r_q_bad_d;
  logic       r_q_open_d;
  logic       w_fail_edge;
  logic       w_succ_edge;
  logic       w_pass;
  logic [3:0] w_fail_inc;

  assign w_fail_edge = q_bad & ~r_q_bad_d;
  assign w_succ_edge = q_opening & ~r_q_open_d;
  assign w_fail_inc  = fail_count + 4'd1;
  assign w_pass      = (w_next_state == ST_IDLE);

  // Success outranks a coincident failure, so it never triggers lockout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:
        if (!w_succ_edge && w_fail_edge && (w_fail_inc == c_max_fails))
          w_next_state = ST_LOCKOUT;
      ST_LOCKOUT:
        if (r_lock_cnt == c_lock_last) w_next_state = ST_REARM;
      ST_REARM:
        if (!btn_u && !btn_z) w_next_state = ST_IDLE;
      default:
        w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_open_tmr <= 8'd0;
      r_lock_cnt <= 8'd0;
      r_q_bad_d  <= 1'b0;
      r_q_open_d <= 1'b0;
      u          <= 1'b0;
      z          <= 1'b0;
      timerout   <= 1'b0;
      locked_out <= 1'b0;
      fail_count <= 4'd0;
    end else begin
      r_state    <= w_next_state;
      r_q_bad_d  <= q_bad;
      r_q_open_d <= q_opening;
      u          <= btn_u & ~btn_z & w_pass;
      z          <= btn_z & ~btn_u & w_pass;

      // Opening timer saturates so a held q_opening yields a single pulse.
      timerout <= q_opening && (r_open_tmr == c_open_last);
      if (!q_opening)
        r_open_tmr <= 8'd0;
      else if (r_open_tmr != c_open_max)
        r_open_tmr <= r_open_tmr + 8'd1;

      case (r_state)
        ST_IDLE: begin
          if (w_succ_edge) begin
            fail_count <= 4'd0;
          end else if (w_fail_edge) begin
            fail_count <= w_fail_inc;
            if (w_fail_inc == c_max_fails) begin
              r_lock_cnt <= 8'd0;
              locked_out <= 1'b1;
            end
          end
        end
        ST_LOCKOUT: begin
          r_lock_cnt <= r_lock_cnt + 8'd1;
          if (r_lock_cnt == c_lock_last) fail_count <= 4'd0;
        end
        ST_REARM: begin
          if (!btn_u && !btn_z) locked_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
